// File: rtl/neosd_card_cmd_if.sv
// Bundle of the card-side CMD line, command report and response request signals.
// resp_valid_i/resp_ready_o: a response is taken on any clk cycle where both are high; payload is sampled only then.
interface neosd_card_cmd_if;
  logic         clkstrb_i;
  logic         sd_cmd_i;
  logic         sd_cmd_o;
  logic         sd_cmd_oe;
  logic         cmd_valid_o;
  logic         cmd_err_o;
  logic [5:0]   cmd_idx_o;
  logic [31:0]  cmd_arg_o;
  logic         resp_ready_o;
  logic         resp_valid_i;
  logic [1:0]   resp_mode_i;
  logic [5:0]   resp_idx_i;
  logic [119:0] resp_data_i;
  logic         busy_o;
  logic [2:0]   dbg_state_o;

  modport slave (
    input  clkstrb_i, sd_cmd_i, resp_valid_i, resp_mode_i, resp_idx_i, resp_data_i,
    output sd_cmd_o, sd_cmd_oe, cmd_valid_o, cmd_err_o, cmd_idx_o, cmd_arg_o,
           resp_ready_o, busy_o, dbg_state_o
  );

  modport master (
    output clkstrb_i, sd_cmd_i, resp_valid_i, resp_mode_i, resp_idx_i, resp_data_i,
    input  sd_cmd_o, sd_cmd_oe, cmd_valid_o, cmd_err_o, cmd_idx_o, cmd_arg_o,
           resp_ready_o, busy_o, dbg_state_o
  );
endinterface

// File: rtl/neosd_card_cmd.sv
// SD card CMD-line responder: receives 48-bit host commands, checks framing and CRC7,
// then sends a none/short/long response after the Ncr gap.
module neosd_card_cmd #(
  parameter int NCR         = 2,
  parameter int NCR_TIMEOUT = 64
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  neosd_card_cmd_if.slave  bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RECV  = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_ARMED = 3'd3;
  localparam logic [2:0] S_SEND  = 3'd4;

  localparam logic [6:0] NCR_W = 7'(NCR);
  localparam logic [6:0] TO_W  = 7'(NCR_TIMEOUT);

  logic [2:0]   r_state;
  logic [5:0]   r_rx_cnt;
  logic [46:0]  r_rx;
  logic [6:0]   r_crc_rx;
  logic [6:0]   r_ncr;
  logic [127:0] r_tx;
  logic [6:0]   r_crc_tx;
  logic [7:0]   r_bit;
  logic         r_long;
  logic         r_cmd_o;
  logic         r_cmd_oe;
  logic         r_valid;
  logic         r_err;
  logic [5:0]   r_idx;
  logic [31:0]  r_arg;

  logic         w_strb;
  logic [47:0]  w_rx_frame;
  logic         w_rx_ok;
  logic [7:0]   w_dlen;
  logic [7:0]   w_end_idx;
  logic         w_tx_bit;
  logic         w_drive;
  logic         w_release;

  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    logic fb;
    fb = c[6] ^ b;
    return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  assign w_strb     = bus.clkstrb_i;
  assign w_rx_frame = {r_rx, bus.sd_cmd_i};
  assign w_rx_ok    = !w_rx_frame[47] && w_rx_frame[46] &&
                      (w_rx_frame[7:1] == r_crc_rx) && w_rx_frame[0];

  // Long frames carry 128 bits ahead of the CRC, short ones 40; the end bit follows 7 CRC bits.
  assign w_dlen    = r_long ? 8'd128 : 8'd40;
  assign w_end_idx = w_dlen + 8'd7;
  assign w_tx_bit  = (r_bit < w_dlen)    ? r_tx[127] :
                     (r_bit < w_end_idx) ? r_crc_tx[6] : 1'b1;
  assign w_drive   = w_strb && (((r_state == S_ARMED) && (r_ncr >= NCR_W)) ||
                                ((r_state == S_SEND) && (r_bit <= w_end_idx)));
  assign w_release = w_strb && (r_state == S_SEND) && (r_bit > w_end_idx);

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_state  <= S_IDLE;
      r_rx_cnt <= '0;
      r_rx     <= '0;
      r_crc_rx <= '0;
      r_ncr    <= '0;
      r_tx     <= '0;
      r_crc_tx <= '0;
      r_bit    <= '0;
      r_long   <= 1'b0;
      r_cmd_o  <= 1'b1;
      r_cmd_oe <= 1'b0;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
      r_idx    <= '0;
      r_arg    <= '0;
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;

      if (w_strb && ((r_state == S_WAIT) || (r_state == S_ARMED)) && (r_ncr != 7'h7F))
        r_ncr <= r_ncr + 7'd1;

      // TX CRC accumulates as data bits leave, then shifts out itself.
      if (w_drive) begin
        r_cmd_oe <= 1'b1;
        r_cmd_o  <= w_tx_bit;
        r_bit    <= r_bit + 8'd1;
        if (r_bit < w_dlen) begin
          r_tx <= {r_tx[126:0], 1'b0};
          if (!r_long || (r_bit >= 8'd8))
            r_crc_tx <= crc7_step(r_crc_tx, r_tx[127]);
        end else begin
          r_crc_tx <= {r_crc_tx[5:0], 1'b0};
        end
      end
      if (w_release) begin
        r_cmd_oe <= 1'b0;
        r_cmd_o  <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (w_strb && !bus.sd_cmd_i) begin
            r_state  <= S_RECV;
            r_rx_cnt <= 6'd1;
            r_rx     <= '0;
            r_crc_rx <= '0;
          end
        end
        S_RECV: begin
          if (w_strb) begin
            r_rx     <= w_rx_frame[46:0];
            r_rx_cnt <= r_rx_cnt + 6'd1;
            if (r_rx_cnt < 6'd40)
              r_crc_rx <= crc7_step(r_crc_rx, bus.sd_cmd_i);
            if (r_rx_cnt == 6'd47) begin
              r_idx <= w_rx_frame[45:40];
              r_arg <= w_rx_frame[39:8];
              if (w_rx_ok) begin
                r_valid <= 1'b1;
                r_ncr   <= 7'd1;
                r_state <= S_WAIT;
              end else begin
                r_err   <= 1'b1;
                r_state <= S_IDLE;
              end
            end
          end
        end
        S_WAIT: begin
          if (bus.resp_valid_i) begin
            r_bit    <= '0;
            r_crc_tx <= '0;
            case (bus.resp_mode_i)
              2'd1: begin
                r_tx    <= {2'b00, bus.resp_idx_i, bus.resp_data_i[31:0], 88'd0};
                r_long  <= 1'b0;
                r_state <= S_ARMED;
              end
              2'd2: begin
                r_tx    <= {2'b00, 6'h3F, bus.resp_data_i};
                r_long  <= 1'b1;
                r_state <= S_ARMED;
              end
              default: r_state <= S_IDLE;
            endcase
          end else if (w_strb && (r_ncr >= TO_W)) begin
            r_state <= S_IDLE;
          end
        end
        S_ARMED: if (w_drive) r_state <= S_SEND;
        S_SEND:  if (w_release) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.sd_cmd_o     = r_cmd_o;
  assign bus.sd_cmd_oe    = r_cmd_oe;
  assign bus.cmd_valid_o  = r_valid;
  assign bus.cmd_err_o    = r_err;
  assign bus.cmd_idx_o    = r_idx;
  assign bus.cmd_arg_o    = r_arg;
  assign bus.resp_ready_o = (r_state == S_WAIT);
  assign bus.busy_o       = (r_state != S_IDLE);
  assign bus.dbg_state_o  = r_state;

endmodule

// File: tb/tb_neosd_card_cmd.sv
// Bench for neosd_card_cmd: host-side command driver, card-model response requests,
// and a scoreboard of expected command reports and response line bits.
module tb_neosd_card_cmd;

  logic clk;
  logic rstn;
  logic strb_d;
  int   n_checks;
  int   n_errors;

  logic [39:0] exp_cmd_q[$];
  logic [0:0]  exp_bit_q[$];

  neosd_card_cmd_if ifc ();

  neosd_card_cmd #(.NCR(2), .NCR_TIMEOUT(64)) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (ifc.slave)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired got=running exp=finished");
    $fatal(1, "simulation timeout");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [135:0] got, input logic [135:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] crc7_model(input logic [119:0] d, input int n);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = n - 1; i >= 0; i--) begin
      fb = c[6] ^ d[i];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  function automatic logic [47:0] mk_cmd(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] h;
    h = {2'b01, idx, arg};
    return {h, crc7_model(120'(h), 40), 1'b1};
  endfunction

  // ---------------- drivers ----------------
  task automatic sd_tick(input logic b);
    @(negedge clk);
    ifc.sd_cmd_i  = b;
    ifc.clkstrb_i = 1'b1;
    @(negedge clk);
    ifc.clkstrb_i = 1'b0;
  endtask

  task automatic send_cmd(input logic [47:0] f, input logic [39:0] exp_report);
    exp_cmd_q.push_back(exp_report);
    for (int i = 47; i >= 0; i--) sd_tick(f[i]);
  endtask

  task automatic push_bits(input logic [135:0] f, input int n);
    for (int i = n - 1; i >= 0; i--) exp_bit_q.push_back(f[i]);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(posedge clk) strb_d <= ifc.clkstrb_i;

  always @(negedge clk) begin
    if (ifc.cmd_valid_o || ifc.cmd_err_o) begin
      if (exp_cmd_q.size() > 0)
        check("cmd_report", {ifc.cmd_err_o, ifc.cmd_valid_o, ifc.cmd_idx_o, ifc.cmd_arg_o},
              exp_cmd_q.pop_front());
      else
        check("cmd_unexpected", ifc.cmd_valid_o | ifc.cmd_err_o, 1'b0);
    end
    if (strb_d) begin
      if (exp_bit_q.size() == 0)
        check("tx_oe_idle", ifc.sd_cmd_oe, 1'b0);
      else if (ifc.sd_cmd_oe)
        check("tx_bit", ifc.sd_cmd_o, exp_bit_q.pop_front());
      if (!ifc.sd_cmd_oe)
        check("idle_line", ifc.sd_cmd_o, 1'b1);
    end
  end

  // ---------------- stimulus ----------------
  logic [127:0] rnd;
  logic [119:0] ldata;
  logic [6:0]   lcrc;
  logic [31:0]  arg_r;

  initial begin
    n_checks          = 0;
    n_errors          = 0;
    rstn              = 1'b0;
    ifc.clkstrb_i     = 1'b0;
    ifc.sd_cmd_i      = 1'b1;
    ifc.resp_valid_i  = 1'b0;
    ifc.resp_mode_i   = 2'd0;
    ifc.resp_idx_i    = 6'd0;
    ifc.resp_data_i   = '0;
    repeat (3) @(negedge clk);

    check("rst_oe",    ifc.sd_cmd_oe,    1'b0);
    check("rst_line",  ifc.sd_cmd_o,     1'b1);
    check("rst_valid", ifc.cmd_valid_o,  1'b0);
    check("rst_err",   ifc.cmd_err_o,    1'b0);
    check("rst_idx",   ifc.cmd_idx_o,    6'd0);
    check("rst_arg",   ifc.cmd_arg_o,    32'd0);
    check("rst_ready", ifc.resp_ready_o, 1'b0);
    check("rst_busy",  ifc.busy_o,       1'b0);
    rstn = 1'b1;
    repeat (4) sd_tick(1'b1);

    // CMD0, no response
    ifc.resp_valid_i = 1'b1;
    ifc.resp_mode_i  = 2'd0;
    send_cmd(48'h400000000095, {2'b01, 6'd0, 32'd0});
    sd_tick(1'b1);
    ifc.resp_valid_i = 1'b0;
    check("cmd0_idle", ifc.busy_o, 1'b0);
    repeat (6) sd_tick(1'b1);

    // CMD8, short response, minimum turnaround
    ifc.resp_valid_i = 1'b1;
    ifc.resp_mode_i  = 2'd1;
    ifc.resp_idx_i   = 6'd8;
    ifc.resp_data_i  = 120'h1AA;
    push_bits(136'h08000001AA13, 48);
    send_cmd(48'h48000001AA87, {2'b01, 6'd8, 32'h1AA});
    sd_tick(1'b1);
    ifc.resp_valid_i = 1'b0;
    check("cmd8_ncr_early", ifc.sd_cmd_oe, 1'b0);
    sd_tick(1'b1);
    check("cmd8_ncr_start", ifc.sd_cmd_oe, 1'b1);
    repeat (52) sd_tick(1'b1);
    check("cmd8_done",    ifc.busy_o, 1'b0);
    check("cmd8_q_empty", exp_bit_q.size(), 0);

    // CMD55 with corrupted CRC/end byte
    send_cmd(48'h770000000064, {2'b10, 6'd55, 32'd0});
    sd_tick(1'b1);
    check("cmd55_ready", ifc.resp_ready_o, 1'b0);
    check("cmd55_busy",  ifc.busy_o,       1'b0);
    repeat (4) sd_tick(1'b1);

    // CMD2, long response
    rnd   = {$urandom(), $urandom(), $urandom(), $urandom()};
    ldata = rnd[119:0];
    lcrc  = crc7_model(ldata, 120);
    push_bits({2'b00, 6'h3F, ldata, lcrc, 1'b1}, 136);
    ifc.resp_valid_i = 1'b1;
    ifc.resp_mode_i  = 2'd2;
    ifc.resp_data_i  = ldata;
    send_cmd(mk_cmd(6'd2, 32'd0), {2'b01, 6'd2, 32'd0});
    sd_tick(1'b1);
    ifc.resp_valid_i = 1'b0;
    repeat (145) sd_tick(1'b1);
    check("cmd2_q_empty", exp_bit_q.size(), 0);
    check("cmd2_idle",    ifc.busy_o, 1'b0);

    // No response request: Ncr timeout
    arg_r = $urandom();
    send_cmd(mk_cmd(6'd17, arg_r), {2'b01, 6'd17, arg_r});
    repeat (63) sd_tick(1'b1);
    check("to_still_wait", ifc.resp_ready_o, 1'b1);
    sd_tick(1'b1);
    check("to_idle", ifc.resp_ready_o, 1'b0);

    // Next command after timeout, mode 3 acts as none
    arg_r = $urandom();
    ifc.resp_valid_i = 1'b1;
    ifc.resp_mode_i  = 2'd3;
    send_cmd(mk_cmd(6'd13, arg_r), {2'b01, 6'd13, arg_r});
    sd_tick(1'b1);
    ifc.resp_valid_i = 1'b0;
    check("mode3_idle", ifc.busy_o, 1'b0);
    repeat (4) sd_tick(1'b1);

    // Reset in the middle of a long response
    rnd   = {$urandom(), $urandom(), $urandom(), $urandom()};
    ldata = rnd[119:0];
    lcrc  = crc7_model(ldata, 120);
    push_bits({2'b00, 6'h3F, ldata, lcrc, 1'b1}, 136);
    ifc.resp_valid_i = 1'b1;
    ifc.resp_mode_i  = 2'd2;
    ifc.resp_data_i  = ldata;
    send_cmd(mk_cmd(6'd9, 32'h12340000), {2'b01, 6'd9, 32'h12340000});
    sd_tick(1'b1);
    ifc.resp_valid_i = 1'b0;
    repeat (30) sd_tick(1'b1);
    check("pre_rst_oe", ifc.sd_cmd_oe, 1'b1);
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    check("mid_rst_oe",    ifc.sd_cmd_oe,    1'b0);
    check("mid_rst_line",  ifc.sd_cmd_o,     1'b1);
    check("mid_rst_busy",  ifc.busy_o,       1'b0);
    check("mid_rst_ready", ifc.resp_ready_o, 1'b0);
    check("mid_rst_idx",   ifc.cmd_idx_o,    6'd0);
    check("mid_rst_arg",   ifc.cmd_arg_o,    32'd0);
    exp_bit_q.delete();
    rstn = 1'b1;
    repeat (4) sd_tick(1'b1);

    ifc.resp_valid_i = 1'b1;
    ifc.resp_mode_i  = 2'd0;
    send_cmd(48'h400000000095, {2'b01, 6'd0, 32'd0});
    sd_tick(1'b1);
    ifc.resp_valid_i = 1'b0;
    check("post_rst_cmd0_idle", ifc.busy_o, 1'b0);
    repeat (4) sd_tick(1'b1);

    check("cmd_q_empty", exp_cmd_q.size(), 0);
    check("bit_q_empty", exp_bit_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/neosd_card_cmd.md
# neosd_card_cmd

Card-side responder for the SD CMD line: the counterpart of the host command FSM. It deserialises 48-bit host commands from sd_cmd, checks direction bit, CRC7 and end bit, presents index/argument to a card model or emulation controller, then serialises the chosen response (none, 48-bit short, 136-bit long) with CRC7 generated internally. It is used as the bus-functional card in host verification and as the front end of FPGA card emulation.

## Interface
- NCR, default 2: minimum SD clocks between command end bit and response start bit (legal 2..64)
- NCR_TIMEOUT, default 64: SD clocks to wait for a response before abandoning it
- clk_i  in  1  system clock
- rstn_i  in  1  reset; synchronous, active-low
- clkstrb_i  in  1  one-cycle strobe marking each SD clock edge; all CMD line sampling and driving happens only on cycles with clkstrb_i=1
- sd_cmd_i  in  1  CMD line input
- sd_cmd_o  out  1  CMD line output data
- sd_cmd_oe  out  1  CMD line output enable
- cmd_valid_o  out  1  one-cycle pulse: good command captured
- cmd_err_o  out  1  one-cycle pulse: bad frame (direction bit 0, CRC mismatch or end bit 0)
- cmd_idx_o  out  6  captured command index (held until next frame)
- cmd_arg_o  out  32  captured argument (held until next frame)
- resp_ready_o  out  1  response may be accepted
- resp_valid_i  in  1  response request
- resp_mode_i  in  2  0 none, 1 short, 2 long, 3 treated as none
- resp_idx_i  in  6  index field of short response
- resp_data_i  in  120  short: [31:0] = argument field; long: [119:0] = CID/CSD bits 127:8
- busy_o  out  1  state not IDLE

## Operation
- States: IDLE, RECV, WAIT, ARMED, SEND. All transitions occur only on clk_i edges where clkstrb_i=1, except response acceptance.
- IDLE: sample sd_cmd_i; 0 (start bit) -> RECV, bit counter = 1.
- RECV: shift sd_cmd_i in MSB first until 48 bits held. CRC7 (x^7+x^3+1, zero seed) runs over bits 47..8. At bit 48: bit 46 must be 1, bits 7..1 must equal CRC, bit 0 must be 1.
  - All pass: latch cmd_idx_o/cmd_arg_o, pulse cmd_valid_o, -> WAIT, Ncr counter = 1.
  - Any fail: latch fields anyway, pulse cmd_err_o, -> IDLE (card never answers bad commands).
- WAIT: resp_ready_o=1. Ncr counter increments per strobe (saturating 7-bit). Handshake resp_valid_i & resp_ready_o on any clk_i cycle:
  - mode none/3: -> IDLE.
  - short: load 48-bit frame {0,0,resp_idx_i,resp_data_i[31:0],CRC7,1}; -> ARMED.
  - long: load 136-bit frame {0,0,6'b111111,resp_data_i,CRC7,1}; CRC7 covers the 120 data bits only; -> ARMED.
  - Counter reaching NCR_TIMEOUT with no handshake: -> IDLE.
- ARMED: counter keeps running; on first strobe with counter >= NCR assert sd_cmd_oe, drive frame MSB, -> SEND.
- SEND: one bit per strobe; after end bit driven for one strobe period, deassert sd_cmd_oe on next strobe, -> IDLE. Receiver ignores line while sending.
- CRC for TX computed serially during load or shift; either is fine provided the transmitted frame is exact.

## Timing
- Reset (synchronous): state IDLE, sd_cmd_oe=0, sd_cmd_o=1, cmd_valid_o=0, cmd_err_o=0, cmd_idx_o=0, cmd_arg_o=0, resp_ready_o=0, busy_o=0. Reset mid-SEND releases line on the reset edge.
- sd_cmd_o/sd_cmd_oe registered; change only on strobe cycles; sd_cmd_o=1 whenever oe=0.
- cmd_valid_o/cmd_err_o assert in the cycle after the strobe that samples the end bit, for exactly one clk_i cycle.
- Minimum turnaround: with resp_valid_i already high, start bit is driven on the NCR-th strobe after the end-bit strobe.
- resp_valid_i outside WAIT is ignored; inputs need only be stable in the handshake cycle.
- Start bit found in IDLE on the same strobe SEND finishes is impossible (line is released first).

## Test plan
- CMD0 arg 0 (0x40 00000000 95) -> cmd_valid_o, idx 0, arg 0; resp mode none -> oe never asserts, back to IDLE.
- CMD8 arg 0x1AA (48 000001AA 87), short resp idx 8 data 0x1AA -> line carries 08 000001AA 13 starting exactly NCR=2 strobes after end bit.
- CMD55 with last byte corrupted to 0x64 -> cmd_err_o pulse, no cmd_valid_o, resp_ready_o stays 0.
- CMD2 then long resp with 120-bit pattern -> 136 bits driven, first byte 0x3F, CRC7 over data matches model, end bit 1, oe drops after.
- Valid command, resp_valid_i never asserted -> return to IDLE after 64 strobes; next command received normally.
- Reset asserted mid-long-response -> sd_cmd_oe=0 and sd_cmd_o=1 on that edge; subsequent CMD0 decodes correctly.
